mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit datapath port among four requesters.
- Drives the 2-bit select of the 4-way operand mux and registers the selected word.
- Grants are one-hot and held while the owner keeps its request asserted.
- Sits between the four result sources (e.g. ALU, shifter, multiplier, memory load) and the shared writeback/bus port.

Parameters:
- WIDTH, 32, data width of each input and of dout.
- MAX_HOLD, 8, maximum consecutive grant cycles before forced release; used only with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i = requester i.
- din_a  input  WIDTH  data of requester 0.
- din_b  input  WIDTH  data of requester 1.
- din_c  input  WIDTH  data of requester 2.
- din_d  input  WIDTH  data of requester 3.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  encoded owner index (00=a, 01=b, 10=c, 11=d), registered.
- busy  output  1  high while any grant is active.
- dout  output  WIDTH  registered data of the current owner.
- dout_valid  output  1  dout holds owner data this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, sel=00, busy=0, dout=0, dout_valid=0, state=IDLE, last-owner pointer=3, so requester 0 has top priority first.
- States:
  - IDLE: no grant.
  - GRANT: one owner.
  - GAP: one mandatory dead cycle after any release.
- IDLE: if req!=0, pick the first set bit scanning from (last+1) mod 4 upward with wrap; next cycle gnt=onehot(winner), sel=winner, busy=1, last=winner, go GRANT. If req==0, stay IDLE.
- GRANT: while req[sel]=1, hold gnt/sel unchanged. When req[sel]=0 at a rising edge, next cycle gnt=0, busy=0, go GAP. Requests from other bits never preempt (except timeout, see below).
- GAP: always lasts exactly one cycle, gnt=0; then behave as IDLE for arbitration. Minimum gnt handover gap is therefore 1 cycle.
- Latency:
  - req rise in IDLE -> gnt at the next edge (1 cycle).
  - dout/dout_valid lag gnt by 1 cycle: dout <= din[sel] and dout_valid <= busy on every edge. When dout_valid=0, dout holds its last value.
- Simultaneous events:
  - Owner drops req in the same cycle another requester raises req: release still goes through GAP.
  - All four requesting: grant order cycles 0,1,2,3,0...
- Requests are level-sensitive; a pulse shorter than one edge is not remembered.
- sel is never X. After reset it is 00 while gnt=0 and keeps the last owner value while idle.
- gnt is never multi-hot. gnt!=0 iff busy=1.
- Reset mid-grant clears everything immediately; the pointer returns to 3.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on each new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and any other req bit is set, force release: next cycle go GAP as if the owner dropped req.
  - The preempted owner keeps requesting and competes again with lowest priority, since the pointer equals its index.
  - If no other requester is waiting, the counter saturates and the grant is held.
- When undefined: no counter is built and grants are held indefinitely while req[owner]=1.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with req=4'b1111 -> all outputs 0 immediately; after release with req=4'b0101, first gnt=4'b0001, sel=00.
- Single requester: req=4'b0100 for 3 cycles, then 0 -> gnt=4'b0100 for 3 cycles starting 1 cycle after req; dout=din_c (e.g. 32'hDEADBEEF) with dout_valid 1 cycle after gnt; then 1 GAP cycle; busy=0.
- Round robin: req=4'b1111, each owner drops req 2 cycles after its grant -> grant order 0,1,2,3,0 with exactly 1 zero-gnt cycle between owners.
- Wrap priority: last owner 3, then req=4'b1001 -> gnt=4'b0001 before 4'b1000.
- No preemption (macro off): owner 1 holds req 20 cycles while req[2]=1 -> gnt=4'b0010 for all 20 cycles, then GAP, then gnt=4'b0100.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=4'b0011 held -> gnt0 for 4 cycles, GAP, gnt1 for 4 cycles, GAP, gnt0 again; with req=4'b0001 only, gnt0 held beyond 4 cycles.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one WIDTH-bit datapath port among four
//   result sources (e.g. ALU, shifter, multiplier, memory load). It owns the
//   2-bit select of the 4-way operand mux and registers the selected word
//   towards the shared writeback/bus port.
//
//   Grants are one-hot, registered, and held for as long as the owner keeps
//   its request high. Every release is followed by exactly one dead cycle
//   (GAP) before the next owner is granted. Arbitration starts scanning at
//   the requester after the last owner, so after reset requester 0 wins
//   first.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   Adds an 8-bit hold counter. Once an owner has held the port for MAX_HOLD
//   cycles and someone else is waiting, the grant is forcibly released.
//   With the macro undefined no counter exists and grants are held
//   indefinitely.
//
// Parameters:
//   WIDTH     data width of din_* and dout
//   MAX_HOLD  max consecutive grant cycles before forced release (2..255),
//             only meaningful with ARB_TIMEOUT_EN
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   req        in   4      request, bit i = requester i (level-sensitive)
//   din_a      in   WIDTH  data of requester 0
//   din_b      in   WIDTH  data of requester 1
//   din_c      in   WIDTH  data of requester 2
//   din_d      in   WIDTH  data of requester 3
//   gnt        out  4      one-hot grant, registered
//   sel        out  2      encoded owner index, registered
//   busy       out  1      high while any grant is active
//   dout       out  WIDTH  registered data of the current owner
//   dout_valid out  1      dout holds owner data this cycle
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] din_c,
  input  logic [WIDTH-1:0] din_d,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  // Reject out-of-range hold limits at elaboration time; the counter is
  // 8 bits wide and a limit below 2 would make every grant a single cycle.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_badMaxHold
    $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  // GAP is a one-cycle dead slot after every release. It arbitrates exactly
  // like IDLE on its way out, which is what makes the handover gap 1 cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } stateT;

  stateT            r_state;
  stateT            w_stateNxt;

  logic [1:0]       r_last;
  logic [3:0]       r_gnt;
  logic [1:0]       r_sel;
  logic             r_busy;
  logic [WIDTH-1:0] r_dout;
  logic             r_doutValid;

  logic             w_found;
  logic [1:0]       w_winner;
  logic             w_release;
  logic             w_timeout;
  logic [3:0]       w_gntNxt;
  logic [1:0]       w_selNxt;
  logic             w_busyNxt;
  logic [1:0]       w_lastNxt;
  logic [WIDTH-1:0] w_dinSel;

  // -------------------------------------------------------------------------
  // Round-robin pick: scan last+1, last+2, last+3, last+4 (mod 4) and take
  // the first requester found. last+4 wraps back to the previous owner, so
  // it only wins when nobody else is asking.
  // -------------------------------------------------------------------------
  always_comb begin
    w_found  = 1'b0;
    w_winner = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && req[r_last + 2'(k)]) begin
        w_found  = 1'b1;
        w_winner = r_last + 2'(k);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // -------------------------------------------------------------------------
  // Hold counter. It sits at zero outside GRANT, so every new grant starts
  // counting from zero; on the first grant cycle it reads 0 and on cycle
  // MAX_HOLD it reads MAX_HOLD-1, which is where a waiting competitor forces
  // a release. With nobody waiting it saturates and the owner keeps the port.
  // -------------------------------------------------------------------------
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold;

  assign w_timeout = (r_hold == HOLD_LAST) && ((req & ~r_gnt) != 4'b0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 8'd0;
    end else if (r_state != GRANT) begin
      r_hold <= 8'd0;
    end else if (!w_release && (r_hold != HOLD_LAST)) begin
      r_hold <= r_hold + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // A grant ends when the owner drops its request or, with the timeout
  // feature, when it has overstayed while someone else is waiting.
  assign w_release = (r_state == GRANT) && (!req[r_sel] || w_timeout);

  // -------------------------------------------------------------------------
  // State register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. IDLE and GAP share the arbitration path; the only
  // difference is that GAP never lingers for more than one cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    w_stateNxt = r_state;
    unique case (r_state)
      IDLE:    w_stateNxt = w_found ? GRANT : IDLE;
      GRANT:   w_stateNxt = w_release ? GAP : GRANT;
      GAP:     w_stateNxt = w_found ? GRANT : IDLE;
      default: w_stateNxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next values of the registered grant, select, busy flag and
  // last-owner pointer. sel and the pointer only move on a new grant, so sel
  // keeps showing the previous owner while the port is idle.
  // -------------------------------------------------------------------------
  always_comb begin
    w_gntNxt  = r_gnt;
    w_selNxt  = r_sel;
    w_busyNxt = r_busy;
    w_lastNxt = r_last;
    unique case (r_state)
      IDLE, GAP: begin
        if (w_found) begin
          w_gntNxt  = 4'b0001 << w_winner;
          w_selNxt  = w_winner;
          w_busyNxt = 1'b1;
          w_lastNxt = w_winner;
        end else begin
          w_gntNxt  = 4'b0000;
          w_busyNxt = 1'b0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_gntNxt  = 4'b0000;
          w_busyNxt = 1'b0;
        end
      end
      default: begin
        w_gntNxt  = 4'b0000;
        w_busyNxt = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Grant/select registers. The pointer resets to 3 so the first scan
  // starts at requester 0.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt  <= 4'b0000;
      r_sel  <= 2'd0;
      r_busy <= 1'b0;
      r_last <= 2'd3;
    end else begin
      r_gnt  <= w_gntNxt;
      r_sel  <= w_selNxt;
      r_busy <= w_busyNxt;
      r_last <= w_lastNxt;
    end
  end

  // -------------------------------------------------------------------------
  // Operand mux driven by the registered select.
  // -------------------------------------------------------------------------
  always_comb begin
    w_dinSel = din_a;
    unique case (r_sel)
      2'd0:    w_dinSel = din_a;
      2'd1:    w_dinSel = din_b;
      2'd2:    w_dinSel = din_c;
      2'd3:    w_dinSel = din_d;
      default: w_dinSel = din_a;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output data register, one cycle behind the grant. dout only loads while
  // a grant is active so it keeps its last word when dout_valid is low.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout      <= '0;
      r_doutValid <= 1'b0;
    end else begin
      r_doutValid <= r_busy;
      if (r_busy) begin
        r_dout <= w_dinSel;
      end
    end
  end

  assign gnt        = r_gnt;
  assign sel        = r_sel;
  assign busy       = r_busy;
  assign dout       = r_dout;
  assign dout_valid = r_doutValid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Purpose:
//   Self-checking bench for mux4_rr_arbiter. A behavioural model tracks the
//   owner as a plain integer (-1 = nobody), the round-robin pointer as an
//   integer mod 4, and the expected dout/dout_valid. Directed sequences cover
//   reset, single requester, round-robin order, wrap priority, no-preemption
//   and (with ARB_TIMEOUT_EN) forced release; a random phase follows.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  localparam int WIDTH       = 32;
  localparam int TB_MAX_HOLD = 4;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] dinA;
  logic [WIDTH-1:0] dinB;
  logic [WIDTH-1:0] dinC;
  logic [WIDTH-1:0] dinD;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             busy;
  logic [WIDTH-1:0] dout;
  logic             doutValid;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state
  int               mOwner;
  int               mLast;
  int               mSel;
  int               mHold;
  int               mAge;
  logic [WIDTH-1:0] mDout;
  logic             mValid;

  mux4_rr_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (TB_MAX_HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din_a      (dinA),
    .din_b      (dinB),
    .din_c      (dinC),
    .din_d      (dinD),
    .gnt        (gnt),
    .sel        (sel),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (doutValid)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] dinOf(input int idx);
    case (idx)
      0:       return dinA;
      1:       return dinB;
      2:       return dinC;
      default: return dinD;
    endcase
  endfunction

  task automatic modelReset();
    mOwner = -1;
    mLast  = 3;
    mSel   = 0;
    mHold  = 0;
    mAge   = 0;
    mDout  = '0;
    mValid = 1'b0;
  endtask

  // One rising edge of the model, using the inputs present before the edge
  task automatic modelStep();
    bit released;
    if (mOwner >= 0) mDout = dinOf(mOwner);
    mValid = (mOwner >= 0);
    if (mOwner >= 0) begin
      released = (req[mOwner] == 1'b0);
`ifdef ARB_TIMEOUT_EN
      if (mHold >= TB_MAX_HOLD - 1 && (req & ~(4'b0001 << mOwner)) != 4'b0000)
        released = 1'b1;
`endif
      if (released) begin
        mOwner = -1;
        mAge   = 0;
      end else begin
        if (mHold < TB_MAX_HOLD - 1) mHold++;
        mAge++;
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int cand;
        cand = (mLast + k) % 4;
        if (mOwner < 0 && req[cand]) mOwner = cand;
      end
      if (mOwner >= 0) begin
        mLast = mOwner;
        mSel  = mOwner;
        mHold = 0;
        mAge  = 1;
      end
    end
  endtask

  task automatic compareAll();
    logic [3:0] expGnt;
    expGnt = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
    checkOutput("gnt",       {28'd0, gnt},       {28'd0, expGnt});
    checkOutput("sel",       {30'd0, sel},       32'(mSel));
    checkOutput("busy",      {31'd0, busy},      {31'd0, (mOwner >= 0)});
    checkOutput("dout",      dout,               mDout);
    checkOutput("doutValid", {31'd0, doutValid}, {31'd0, mValid});
  endtask

  task automatic driveInputs(input logic [3:0] reqv);
    req  = reqv;
    dinA = $urandom;
    dinB = $urandom;
    dinC = $urandom;
    dinD = $urandom;
  endtask

  task automatic stepAndCheck();
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input logic [3:0] reqv);
    @(negedge clk);
    driveInputs(reqv);
    stepAndCheck();
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    modelReset();
    #1;
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rrOrder[$];
    logic [3:0] rrExpected [5];
    logic [3:0] prevGnt;
    logic [3:0] reqv;
    int         heldCount;

    rrExpected = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0;
    driveInputs(4'b0000);
    modelReset();
    #2;
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset during an active grant
    for (int c = 0; c < 3; c++) applyStimulus(4'b1111);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;
    driveInputs(4'b0101);
    stepAndCheck();
    checkOutput("afterResetGnt", {28'd0, gnt}, 32'h1);
    checkOutput("afterResetSel", {30'd0, sel}, 32'h0);

    // Single requester on port c for three cycles, then release
    pulseReset();
    for (int c = 0; c < 3; c++) applyStimulus(4'b0100);
    for (int c = 0; c < 3; c++) applyStimulus(4'b0000);

    // Round robin with all four requesting, each owner leaving after 2 cycles
    pulseReset();
    prevGnt = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      reqv = 4'b1111;
      if (mOwner >= 0 && mAge >= 2) reqv[mOwner] = 1'b0;
      applyStimulus(reqv);
      if (gnt != 4'b0000 && gnt != prevGnt) rrOrder.push_back(gnt);
      prevGnt = gnt;
    end
    checkOutput("rrCount", {31'd0, (rrOrder.size() >= 5)}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i < rrOrder.size()) checkOutput("rrOrder", {28'd0, rrOrder[i]}, {28'd0, rrExpected[i]});
    end

    // Wrap priority: after owner 3, requester 0 beats requester 3
    applyStimulus(4'b0000);
    applyStimulus(4'b1000);
    applyStimulus(4'b1000);
    applyStimulus(4'b0000);
    applyStimulus(4'b1001);
    checkOutput("wrapFirst", {28'd0, gnt}, 32'h1);
    applyStimulus(4'b1000);
    applyStimulus(4'b1000);
    checkOutput("wrapSecond", {28'd0, gnt}, 32'h8);

    // Owner 1 holds for 20 cycles while requester 2 waits
    pulseReset();
    applyStimulus(4'b0001);
    applyStimulus(4'b0000);
    heldCount = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(4'b0110);
      if (gnt == 4'b0010) heldCount++;
    end
`ifndef ARB_TIMEOUT_EN
    checkOutput("noPreemptHeld", 32'(heldCount), 32'd20);
`endif
    applyStimulus(4'b0100);
    checkOutput("handoverGap", {28'd0, gnt}, 32'h0);
    applyStimulus(4'b0100);
    checkOutput("handoverNext", {28'd0, gnt}, 32'h4);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);

`ifdef ARB_TIMEOUT_EN
    // Forced release with MAX_HOLD=4, then a lone requester is not cut off
    pulseReset();
    for (int c = 0; c < 11; c++) begin
      logic [3:0] expT;
      applyStimulus(4'b0011);
      expT = (c < 4) ? 4'b0001 : (c == 4) ? 4'b0000 : (c < 9) ? 4'b0010 :
             (c == 9) ? 4'b0000 : 4'b0001;
      checkOutput("timeoutSeq", {28'd0, gnt}, {28'd0, expT});
    end
    for (int c = 0; c < 10; c++) applyStimulus(4'b0001);
    checkOutput("timeoutLoneHeld", {28'd0, gnt}, 32'h1);
`endif

    // Random phase: requests persist for a while, then change
    pulseReset();
    reqv = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) reqv = 4'($urandom_range(0, 15));
      if (mOwner >= 0 && $urandom_range(0, 5) == 0) reqv[mOwner] = 1'b0;
      applyStimulus(reqv);
      if (c == 200) pulseReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
